// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Definitions shared by the square sequencer and related decoders.
//   sqw(sw)  : width of a squared value of an sw-bit operand (2*sw)
//   DIR_UP   : dir encoding for counting up
//   DIR_DOWN : dir encoding for counting down
// -----------------------------------------------------------------------------
package seq_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic int sqw(input int sw);
    return 2 * sw;
  endfunction

endpackage

// File: rtl/cc_quadrado.sv
// -----------------------------------------------------------------------------
// cc_quadrado
// Purely combinational squarer: o_sq = i_a * i_a at full 2*SW width.
// Ports:
//   i_a  in  SW      operand
//   o_sq out 2*SW    square of the operand, never truncated
// -----------------------------------------------------------------------------
module cc_quadrado
  import seq_pkg::*;
#(
  parameter int SW = 4
) (
  input  logic [SW-1:0]      i_a,
  output logic [sqw(SW)-1:0] o_sq
);

  logic [sqw(SW)-1:0] w_a_ext;

  // Widen before multiplying so the product is evaluated at 2*SW bits.
  assign w_a_ext = {{SW{1'b0}}, i_a};
  assign o_sq    = w_a_ext * w_a_ext;

endmodule

// File: rtl/sequenciador_quadrado.sv
// -----------------------------------------------------------------------------
// sequenciador_quadrado
// Moore up/down sequencer over 0..LAST with wrap, whose square is delivered
// through a one-entry valid/ready output buffer.
// Parameters:
//   SW   state width in bits
//   LAST final state value (LAST < 2**SW)
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   en        in   step request
//   dir       in   0 = up, 1 = down
//   load      in   load request (priority over en)
//   load_val  in   SW    value to load, clamped to LAST
//   ea        out  SW    current state
//   sq        out  2*SW  registered ea*ea
//   sq_valid  out  sq holds an unconsumed result
//   sq_ready  in   consumer accepts sq this cycle
//   done      out  one-cycle pulse after a wrap
//   sq_par    out  even parity of sq (only when SQ_PARITY_EN is defined)
// Optional feature macro: SQ_PARITY_EN
// -----------------------------------------------------------------------------
module sequenciador_quadrado
  import seq_pkg::*;
#(
  parameter int SW   = 4,
  parameter int LAST = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               dir,
  input  logic               load,
  input  logic [SW-1:0]      load_val,
  output logic [SW-1:0]      ea,
  output logic [sqw(SW)-1:0] sq,
  output logic               sq_valid,
  input  logic               sq_ready,
`ifdef SQ_PARITY_EN
  output logic               sq_par,
`endif
  output logic               done
);

  localparam logic [SW-1:0] LAST_V = LAST[SW-1:0];
  localparam logic [SW-1:0] ZERO_V = '0;
  localparam logic [SW-1:0] ONE_V  = {{(SW-1){1'b0}}, 1'b1};

  logic [SW-1:0]      r_ea;
  logic [sqw(SW)-1:0] r_sq;
  logic               r_sq_valid;
  logic               r_done;
`ifdef SQ_PARITY_EN
  logic               r_sq_par;
`endif

  logic [SW-1:0]      w_next;
  logic               w_req;
  logic               w_wrap;
  logic               w_slot_free;
  logic               w_update;
  logic [sqw(SW)-1:0] w_sq;

  // The buffer can take a new result when empty or being drained this cycle.
  // sq_ready only reaches the update enable, never sq/sq_valid directly.
  assign w_slot_free = !r_sq_valid || sq_ready;
  assign w_update    = w_req && w_slot_free;

  always_comb begin
    w_next = r_ea;
    w_req  = 1'b0;
    w_wrap = 1'b0;
    if (load) begin
      w_req  = 1'b1;
      w_next = (load_val > LAST_V) ? LAST_V : load_val;
    end else if (en) begin
      w_req = 1'b1;
      if (dir == DIR_UP) begin
        if (r_ea == LAST_V) begin
          w_next = ZERO_V;
          w_wrap = 1'b1;
        end else begin
          w_next = r_ea + ONE_V;
        end
      end else begin
        if (r_ea == ZERO_V) begin
          w_next = LAST_V;
          w_wrap = 1'b1;
        end else begin
          w_next = r_ea - ONE_V;
        end
      end
    end
  end

  cc_quadrado #(.SW(SW)) u_quadrado (
    .i_a  (w_next),
    .o_sq (w_sq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ea       <= '0;
      r_sq       <= '0;
      r_sq_valid <= 1'b0;
      r_done     <= 1'b0;
`ifdef SQ_PARITY_EN
      r_sq_par   <= 1'b0;
`endif
    end else begin
      // done rises together with the wrapped state value.
      r_done <= w_update && w_wrap;
      if (w_update) begin
        r_ea       <= w_next;
        r_sq       <= w_sq;
        r_sq_valid <= 1'b1;
`ifdef SQ_PARITY_EN
        r_sq_par   <= ^w_sq;
`endif
      end else if (r_sq_valid && sq_ready) begin
        r_sq_valid <= 1'b0;
      end
    end
  end

  assign ea       = r_ea;
  assign sq       = r_sq;
  assign sq_valid = r_sq_valid;
  assign done     = r_done;
`ifdef SQ_PARITY_EN
  assign sq_par   = r_sq_par;
`endif

endmodule

// File: tb/tb_sequenciador_quadrado.sv
module tb_sequenciador_quadrado;

  localparam int SW   = 4;
  localparam int LAST = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              dir;
  logic              load;
  logic [SW-1:0]     load_val;
  logic [SW-1:0]     ea;
  logic [2*SW-1:0]   sq;
  logic              sq_valid;
  logic              sq_ready;
  logic              done;
`ifdef SQ_PARITY_EN
  logic              sq_par;
`endif

  sequenciador_quadrado #(.SW(SW), .LAST(LAST)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .ea       (ea),
    .sq       (sq),
    .sq_valid (sq_valid),
    .sq_ready (sq_ready),
`ifdef SQ_PARITY_EN
    .sq_par   (sq_par),
`endif
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ld; int lv; bit en; bit dir; bit rdy;
    int e_ea; int e_sq; bit e_v; bit e_d;
  } vec_t;

  vec_t vq[$];
  int errors = 0;
  int checks = 0;

  // reference model state
  int m_ea, m_sq;
  bit m_valid, m_done;

  function automatic void add(bit ld, int lv, bit e, bit d, bit r,
                              int xea, int xsq, bit xv, bit xd);
    vec_t v;
    v.ld = ld; v.lv = lv; v.en = e; v.dir = d; v.rdy = r;
    v.e_ea = xea; v.e_sq = xsq; v.e_v = xv; v.e_d = xd;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input bit ld, input int lv, input bit e, input bit d, input bit r);
    load = ld; load_val = lv[SW-1:0]; en = e; dir = d; sq_ready = r;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".ea"}, 32'(ea), 0);
    chk({tag, ".sq"}, 32'(sq), 0);
    chk({tag, ".valid"}, 32'(sq_valid), 0);
    chk({tag, ".done"}, 32'(done), 0);
  endtask

  // Model: sequence 0..LAST treated as a ring of LAST+1 values.
  task automatic model_step();
    int nxt;
    bit req, wrap, free;
    nxt = m_ea; req = 0; wrap = 0;
    free = !m_valid || sq_ready;
    if (load) begin
      req = 1;
      nxt = (int'(load_val) < LAST) ? int'(load_val) : LAST;
    end else if (en) begin
      req = 1;
      if (dir == 1'b0) begin
        nxt  = (m_ea + 1) % (LAST + 1);
        wrap = nxt < m_ea;
      end else begin
        nxt  = (m_ea + LAST) % (LAST + 1);
        wrap = nxt > m_ea;
      end
    end
    m_done = free && req && wrap;
    if (free && req) begin
      m_ea = nxt; m_sq = nxt * nxt; m_valid = 1;
    end else if (m_valid && sq_ready) begin
      m_valid = 0;
    end
  endtask

  initial begin
    // vector table: from reset, up count 1..11 then wrap to 0
    for (int k = 1; k <= LAST; k++) add(0, 0, 1, 0, 1, k, k * k, 1, 0);
    add(0, 0, 1, 0, 1, 0, 0, 1, 1);
    // climb to 5, then backpressure for 3 cycles, then release
    for (int k = 1; k <= 5; k++) add(0, 0, 1, 0, 1, k, k * k, 1, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 1, 0, 0, 5, 25, 1, 0);
    add(0, 0, 1, 0, 1, 6, 36, 1, 0);
    // count down to 0, wrap to LAST, one more step
    for (int k = 5; k >= 0; k--) add(0, 0, 1, 1, 1, k, k * k, 1, 0);
    add(0, 0, 1, 1, 1, 11, 121, 1, 1);
    add(0, 0, 1, 1, 1, 10, 100, 1, 0);
    // loads: priority over en, clamping
    add(1, 7, 1, 1, 1, 7, 49, 1, 0);
    add(1, 14, 0, 0, 1, 11, 121, 1, 0);
    // drain, idle, load into an empty slot without ready, then stall
    add(0, 0, 0, 0, 1, 11, 121, 0, 0);
    add(0, 0, 0, 0, 0, 11, 121, 0, 0);
    add(1, 3, 0, 0, 0, 3, 9, 1, 0);
    add(0, 0, 1, 0, 0, 3, 9, 1, 0);
    add(1, 9, 0, 0, 0, 3, 9, 1, 0);
    add(0, 0, 1, 0, 1, 4, 16, 1, 0);
    // clamped load of max value then wrap upward
    add(1, 15, 0, 0, 1, 11, 121, 1, 0);
    add(0, 0, 1, 0, 1, 0, 0, 1, 1);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    #3;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].ld, vq[i].lv, vq[i].en, vq[i].dir, vq[i].rdy);
      @(posedge clk); #1;
      $display("vec %0d: ld=%0d lv=%0d en=%0d dir=%0d rdy=%0d -> ea=%0d sq=%0d v=%0d d=%0d",
               i, vq[i].ld, vq[i].lv, vq[i].en, vq[i].dir, vq[i].rdy, ea, sq, sq_valid, done);
      chk($sformatf("vec%0d.ea", i), 32'(ea), vq[i].e_ea);
      chk($sformatf("vec%0d.sq", i), 32'(sq), vq[i].e_sq);
      chk($sformatf("vec%0d.valid", i), 32'(sq_valid), 32'(vq[i].e_v));
      chk($sformatf("vec%0d.done", i), 32'(done), 32'(vq[i].e_d));
`ifdef SQ_PARITY_EN
      chk($sformatf("vec%0d.par", i), 32'(sq_par), $countones(vq[i].e_sq) % 2);
`endif
    end

    // asynchronous reset in the middle of a count at ea=6
    drive(1, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("mid.load0", 32'(ea), 0);
    drive(0, 0, 1, 0, 1);
    repeat (6) begin @(posedge clk); #1; end
    chk("mid.ea6", 32'(ea), 6);
    chk("mid.sq36", 32'(sq), 36);
    #2 rst = 1'b1;
    #1;
    $display("async reset at t=%0t: ea=%0d sq=%0d v=%0d d=%0d", $time, ea, sq, sq_valid, done);
    check_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;

    // randomized run against the reference model
    m_ea = 0; m_sq = 0; m_valid = 0; m_done = 0;
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(7) == 0), $urandom_range(15), ($urandom_range(3) != 0),
            $urandom_range(1), ($urandom_range(2) != 0));
      model_step();
      @(posedge clk); #1;
      $display("rnd %0d: ld=%0d lv=%0d en=%0d dir=%0d rdy=%0d -> ea=%0d sq=%0d v=%0d d=%0d",
               n, load, load_val, en, dir, sq_ready, ea, sq, sq_valid, done);
      chk($sformatf("rnd%0d.ea", n), 32'(ea), m_ea);
      chk($sformatf("rnd%0d.sq", n), 32'(sq), m_sq);
      chk($sformatf("rnd%0d.valid", n), 32'(sq_valid), 32'(m_valid));
      chk($sformatf("rnd%0d.done", n), 32'(done), 32'(m_done));
`ifdef SQ_PARITY_EN
      chk($sformatf("rnd%0d.par", n), 32'(sq_par), $countones(m_sq) % 2);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sequenciador_quadrado.md
# sequenciador_quadrado

Parametrised Moore sequencer that generalises our fixed 4-bit state/output decoder pair into one registered block. Holds a state register `ea` of configurable width and steps it up or down with wrap at a programmable last state. Drives the square of the new state on `sq` through a one-entry valid/ready output buffer. Sits between the control FSM (step/load commands) and the display/consumer path that previously took the combinational decoder output directly.

## Interface
- `SW`, 4: state width in bits.
- `LAST`, 11: final state value, with `LAST` < 2^SW. The state sequence is 0..LAST.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: request one step this cycle.
- `dir`  in  1: 0 = count up, 1 = count down.
- `load`  in  1: request load of `load_val`; takes priority over `en`.
- `load_val`  in  SW: value to load.
- `ea`  out  SW: current state.
- `sq`  out  2*SW: registered `ea*ea`.
- `sq_valid`  out  1: `sq` holds an unconsumed result.
- `sq_ready`  in  1: consumer accepts `sq` this cycle.
- `done`  out  1: one-cycle pulse on the cycle after a wrap.

## Operation
- Reset values: `ea` = 0, `sq` = 0, `sq_valid` = 0, `done` = 0 (and `sq_par` = 0 when present).
- Slot free when `!sq_valid || sq_ready`. An update (load or step) happens only when the slot is free. Otherwise the request is ignored that cycle and the requester must hold it.
- Update priority: `load` > `en`. With neither asserted, `ea` holds.
- Load: `ea` <= min(`load_val`, `LAST`). Values above `LAST` clamp to `LAST`. Load never sets `done`.
- Step up: if `ea` == `LAST`, next = 0 and `done` fires; otherwise next = `ea`+1.
- Step down: if `ea` == 0, next = `LAST` and `done` fires; otherwise next = `ea`−1.
- On any update: `sq` <= next*next, computed at full 2*SW width with no truncation, and `sq_valid` <= 1.
- No update but `sq_valid && sq_ready`: `sq_valid` <= 0, and `sq` keeps its last value.
- Simultaneous update and accept: the new result replaces the old one, `sq_valid` stays 1, and nothing is lost.
- `done` is 0 on every cycle that did not follow a wrap.
- `rst` asserted mid-operation clears everything immediately. Any pending or held result is discarded.

## Timing
- Latency is 1 cycle: a command accepted at edge n shows `ea`/`sq`/`sq_valid` after edge n.
- `done` is registered and is high in the same cycle the wrapped `ea` value appears.
- Throughput is one result per cycle while `sq_ready` = 1.
- Under backpressure (`sq_valid`=1, `sq_ready`=0), `ea`, `sq`, and `sq_valid` are all stable.
- No combinational path from `sq_ready` to `sq` or `sq_valid`. The path from `sq_ready` to internal update-enable is allowed.

## Configuration
- `SQ_PARITY_EN` defined:
  - Adds output `sq_par` (1 bit), the even-parity bit (XOR of all bits of `sq`).
  - `sq_par` is registered alongside `sq` and updates under the same rules.
- `SQ_PARITY_EN` undefined: the port `sq_par` and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `seq_pkg` holds:
  - width function `sqw(SW)` = 2*SW;
  - the direction constants `DIR_UP`/`DIR_DOWN`.
- Sub-module `cc_quadrado`: a purely combinational SW → 2*SW squarer that computes next*next. It is instantiated once and is reusable by other decoders.
- Next-state logic, output buffer, and `done` register live in the top module.

## Test plan
All scenarios use SW=4 and LAST=11.
1. Reset: assert `rst` mid-count (`ea`=6) → `ea`=0, `sq`=0, `sq_valid`=0, `done`=0 asynchronously.
2. Up count: `en`=1, `dir`=0, `sq_ready`=1 from reset → `ea` 1,2,…,11,0 and `sq` 1,4,…,121,0. `done`=1 only with `ea`=0.
3. Backpressure: at `ea`=5/`sq`=25/`sq_valid`=1, `sq_ready`=0 for 3 cycles with `en`=1 → everything holds. Then `sq_ready`=1 → `ea`=6, `sq`=36.
4. Down wrap: `ea`=0, `dir`=1, `en`=1 → `ea`=11, `sq`=121, `done`=1. Next step gives `ea`=10, `sq`=100, `done`=0.
5. Load: `load_val`=7 with `en`=1 → `ea`=7, `sq`=49, `done`=0. `load_val`=14 → clamped to `ea`=11, `sq`=121.
6. Parity (`SQ_PARITY_EN`): `sq`=121 (0111_1001) → `sq_par`=1. `sq`=36 (0010_0100) → `sq_par`=0.
